// File: rtl/br_ecc_sed_chunked_decoder_pkg.sv
// Shared helpers for the chunked single-error-detect decoder.
// Only index arithmetic lives here; the decoder sizes itself from its own
// parameters.
package br_ecc_sed_chunked_decoder_pkg;

  // Lowest data bit covered by chunk idx.
  function automatic int sed_chunk_lsb(input int idx, input int chunk_width);
    return idx * chunk_width;
  endfunction

  // Highest data bit covered by chunk idx; the last chunk stops at the top
  // of the data field instead of running past it.
  function automatic int sed_chunk_msb(input int idx, input int chunk_width,
                                       input int data_width);
    int hi;
    hi = (idx + 1) * chunk_width - 1;
    if (hi > data_width - 1) begin
      hi = data_width - 1;
    end
    return hi;
  endfunction

endpackage

// File: rtl/br_flow_reg_fwd.sv
// Forward-registered valid/ready pipeline stage.
// Handshake: a beat moves whenever valid && ready on a rising clk edge;
// once valid is raised, valid and data stay put until ready is seen.
// push_ready depends only on the stage's own state and pop_ready, so a full
// stage refills in the same cycle it drains (full throughput).
module br_flow_reg_fwd #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [Width-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [Width-1:0] pop_data
);

  logic             valid_q;
  logic             valid_d;
  logic [Width-1:0] data_q;
  logic [Width-1:0] data_d;

  assign push_ready = !valid_q || pop_ready;
  assign pop_valid  = valid_q;
  assign pop_data   = data_q;

  // Next state: occupied if a beat arrives or the held beat is not taken.
  always_comb begin
    valid_d = push_valid || (valid_q && !pop_ready);
    data_d  = data_q;
    if (push_valid && push_ready) begin
      data_d = push_data;
    end
  end

  // Occupancy flag is reset so a held word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload register is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/br_ecc_sed_chunked_decoder.sv
// Chunked single-error-detect decoder.
// Each parity bit guards one ChunkWidth slice of the data (even parity).
// The codeword is forwarded uncorrected with its per-chunk syndrome one
// cycle after acceptance; an error counter, a sticky flag and the first
// error syndrome are kept alongside for monitoring.
module br_ecc_sed_chunked_decoder
  import br_ecc_sed_chunked_decoder_pkg::*;
#(
  parameter int DataWidth                 = 8,
  parameter int ChunkWidth                = 4,
  parameter int ErrorCountWidth           = 8,
  parameter int EnableAssertFinalNotValid = 1,
  localparam int NumChunks     = (DataWidth + ChunkWidth - 1) / ChunkWidth,
  localparam int ParityWidth   = NumChunks,
  localparam int CodewordWidth = DataWidth + ParityWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rcv_valid,
  output logic                       rcv_ready,
  input  logic [CodewordWidth-1:0]   rcv_codeword,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [CodewordWidth-1:0]   dec_codeword,
  output logic [DataWidth-1:0]       dec_data,
  output logic [NumChunks-1:0]       dec_error_syndrome,
  output logic                       dec_error_due,
  output logic [ErrorCountWidth-1:0] err_count,
  input  logic                       err_count_clear,
  output logic                       err_sticky,
  output logic [NumChunks-1:0]       err_first_syndrome
);

  localparam int StageWidth = CodewordWidth + NumChunks + 1;
  localparam logic [ErrorCountWidth-1:0] CountMax = '1;
  localparam logic [ErrorCountWidth-1:0] CountOne = ErrorCountWidth'(1);

  // Parameter range checks at elaboration.
  if (DataWidth < 1) begin : g_bad_data_width
    $error("DataWidth must be at least 1");
  end
  if (ChunkWidth < 1 || ChunkWidth > DataWidth) begin : g_bad_chunk_width
    $error("ChunkWidth must be in 1..DataWidth");
  end
  if (ErrorCountWidth < 1) begin : g_bad_count_width
    $error("ErrorCountWidth must be at least 1");
  end

  logic [NumChunks-1:0] rcv_syndrome;
  logic                 rcv_due;
  logic                 rcv_xfer;
  logic                 rcv_err;

  // One syndrome bit per chunk: its parity bit XORed with its data slice.
  for (genvar gi = 0; gi < NumChunks; gi++) begin : g_syndrome
    localparam int Lsb = sed_chunk_lsb(gi, ChunkWidth);
    localparam int Msb = sed_chunk_msb(gi, ChunkWidth, DataWidth);
    assign rcv_syndrome[gi] = rcv_codeword[DataWidth + gi] ^ (^rcv_codeword[Msb:Lsb]);
  end

  assign rcv_due  = |rcv_syndrome;
  assign rcv_xfer = rcv_valid && rcv_ready;
  assign rcv_err  = rcv_xfer && rcv_due;

  logic [StageWidth-1:0] stage_in;
  logic [StageWidth-1:0] stage_out;

  assign stage_in = {rcv_codeword, rcv_syndrome, rcv_due};

  br_flow_reg_fwd #(
    .Width (StageWidth)
  ) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .push_valid (rcv_valid),
    .push_ready (rcv_ready),
    .push_data  (stage_in),
    .pop_valid  (dec_valid),
    .pop_ready  (dec_ready),
    .pop_data   (stage_out)
  );

  assign dec_codeword       = stage_out[StageWidth-1 -: CodewordWidth];
  assign dec_error_syndrome = stage_out[NumChunks:1];
  assign dec_error_due      = stage_out[0];
  assign dec_data           = dec_codeword[DataWidth-1:0];

  logic [ErrorCountWidth-1:0] err_count_q;
  logic [ErrorCountWidth-1:0] err_count_d;
  logic                       err_sticky_q;
  logic                       err_sticky_d;
  logic [NumChunks-1:0]       err_first_q;
  logic [NumChunks-1:0]       err_first_d;

  // Error monitor: count errored acceptances (saturating), remember the
  // first syndrome; a clear restarts tracking from the coincident transfer.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    err_first_d  = err_first_q;
    if (err_count_clear) begin
      err_count_d  = rcv_err ? CountOne : '0;
      err_sticky_d = rcv_err;
      err_first_d  = rcv_err ? rcv_syndrome : '0;
    end else if (rcv_err) begin
      if (err_count_q != CountMax) begin
        err_count_d = err_count_q + CountOne;
      end
      if (!err_sticky_q) begin
        err_sticky_d = 1'b1;
        err_first_d  = rcv_syndrome;
      end
    end
  end

  // Error monitor state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
      err_first_q  <= '0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
      err_first_q  <= err_first_d;
    end
  end

  assign err_count          = err_count_q;
  assign err_sticky         = err_sticky_q;
  assign err_first_syndrome = err_first_q;

`ifndef SYNTHESIS
  // A stalled output word must not move or disappear.
  a_hold_under_backpressure : assert property (@(posedge clk) disable iff (rst)
    (dec_valid && !dec_ready) |=> (dec_valid && $stable(dec_codeword) &&
                                   $stable(dec_error_syndrome) && $stable(dec_error_due)));

  // Counter only moves up between clears.
  a_count_monotonic : assert property (@(posedge clk) disable iff (rst)
    !err_count_clear |=> (err_count >= $past(err_count)));

  c_due_seen : cover property (@(posedge clk) disable iff (rst)
    dec_valid && dec_error_due);

  c_count_saturated : cover property (@(posedge clk) disable iff (rst)
    (err_count == CountMax) && rcv_err && !err_count_clear);

  // Nothing should be left in flight at end of simulation.
  final begin
    if (EnableAssertFinalNotValid != 0) begin
      a_final_not_valid : assert (!dec_valid)
        else $error("dec_valid still high at end of simulation");
    end
  end
`endif

endmodule

// File: tb/tb_br_ecc_sed_chunked_decoder.sv
// Directed + randomized bench for the chunked SED decoder (8 data bits,
// 4-bit chunks, 2-bit error counter).
module tb_br_ecc_sed_chunked_decoder;

  localparam int DW  = 8;
  localparam int CWD = 4;
  localparam int ECW = 2;
  localparam int NC  = 2;
  localparam int CW  = DW + NC;
  localparam int W   = CW + NC + 1;

  logic           clk;
  logic           rst;
  logic           rcv_valid;
  logic           rcv_ready;
  logic [CW-1:0]  rcv_codeword;
  logic           dec_valid;
  logic           dec_ready;
  logic [CW-1:0]  dec_codeword;
  logic [DW-1:0]  dec_data;
  logic [NC-1:0]  dec_error_syndrome;
  logic           dec_error_due;
  logic [ECW-1:0] err_count;
  logic           err_count_clear;
  logic           err_sticky;
  logic [NC-1:0]  err_first_syndrome;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [W-1:0]   exp_q[$];
  logic [ECW-1:0] exp_count;
  logic           exp_sticky;
  logic [NC-1:0]  exp_first;
  bit             bp_en;

  br_ecc_sed_chunked_decoder #(
    .DataWidth                 (DW),
    .ChunkWidth                (CWD),
    .ErrorCountWidth           (ECW),
    .EnableAssertFinalNotValid (1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rcv_valid          (rcv_valid),
    .rcv_ready          (rcv_ready),
    .rcv_codeword       (rcv_codeword),
    .dec_valid          (dec_valid),
    .dec_ready          (dec_ready),
    .dec_codeword       (dec_codeword),
    .dec_data           (dec_data),
    .dec_error_syndrome (dec_error_syndrome),
    .dec_error_due      (dec_error_due),
    .err_count          (err_count),
    .err_count_clear    (err_count_clear),
    .err_sticky         (err_sticky),
    .err_first_syndrome (err_first_syndrome)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference syndrome: walk every data bit into its chunk's accumulator.
  function automatic logic [NC-1:0] model_syn(input logic [CW-1:0] cw);
    logic [NC-1:0] s;
    s = cw[CW-1:DW];
    for (int b = 0; b < DW; b++) begin
      s[b / CWD] = s[b / CWD] ^ cw[b];
    end
    return s;
  endfunction

  task automatic model_reset();
    exp_count  = '0;
    exp_sticky = 1'b0;
    exp_first  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one codeword (optionally with clear) until accepted, then update
  // the scoreboard and the counter model.
  task automatic drive(input logic [CW-1:0] cw, input logic clr);
    logic          got;
    logic [NC-1:0] s;
    int            n;
    rcv_valid       = 1'b1;
    rcv_codeword    = cw;
    err_count_clear = clr;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = rcv_ready;
      tick();
      n++;
    end
    rcv_valid       = 1'b0;
    err_count_clear = 1'b0;
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      s = model_syn(cw);
      exp_q.push_back({cw, s, |s});
      if (clr) begin
        exp_count  = (|s) ? ECW'(1) : '0;
        exp_sticky = |s;
        exp_first  = (|s) ? s : '0;
      end else if (|s) begin
        if (exp_count != '1) exp_count = exp_count + ECW'(1);
        if (!exp_sticky) begin
          exp_sticky = 1'b1;
          exp_first  = s;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    rcv_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_err_state(input string tag);
    chk({tag, "_count"}, 32'(err_count), 32'(exp_count));
    chk({tag, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
    chk({tag, "_first"}, 32'(err_first_syndrome), 32'(exp_first));
  endtask

  // Scoreboard: compare each delivered word against the expected queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("dec_codeword", 32'(dec_codeword), 32'(e[W-1 -: CW]));
        chk("dec_data", 32'(dec_data), 32'(e[W-CW+DW-1 -: DW]));
        chk("dec_syndrome", 32'(dec_error_syndrome), 32'(e[NC:1]));
        chk("dec_due", 32'(dec_error_due), 32'(e[0]));
      end
    end
  end

  initial begin
    logic [CW-1:0] word_a;
    rst             = 1'b1;
    rcv_valid       = 1'b0;
    rcv_codeword    = '0;
    dec_ready       = 1'b1;
    err_count_clear = 1'b0;
    bp_en           = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_rcv_ready", 32'(rcv_ready), 32'd1);
    chk_err_state("rst");
    tick();
    chk("post_rst_rcv_ready", 32'(rcv_ready), 32'd1);

    // Clean words: one-cycle latency, zero syndrome, no count.
    drive(10'h213, 1'b0);
    chk("lat_213", 32'(dec_valid), 32'd1);
    drive(10'h00F, 1'b0);
    chk("lat_00f", 32'(dec_valid), 32'd1);
    idle(2);
    chk("clean_dec_valid_idle", 32'(dec_valid), 32'd0);
    chk("clean_count_const", 32'(err_count), 32'd0);
    chk_err_state("clean");

    // Single-chunk errors in each chunk.
    drive(10'h00E, 1'b0);
    drive(10'h013, 1'b0);
    idle(2);
    chk("two_err_count_const", 32'(err_count), 32'd2);
    chk("two_err_first_const", 32'(err_first_syndrome), 32'd1);
    chk_err_state("two_err");

    // Five back-to-back errors saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) drive(10'h00E, 1'b0);
    idle(2);
    chk("sat_count_const", 32'(err_count), 32'd3);
    chk_err_state("sat");

    // Clear on its own.
    err_count_clear = 1'b1;
    tick();
    err_count_clear = 1'b0;
    model_reset();
    chk_err_state("clear_alone");

    // Clear coinciding with an errored transfer, then a later error.
    drive(10'h00E, 1'b1);
    chk("clr_err_count_const", 32'(err_count), 32'd1);
    chk("clr_err_first_const", 32'(err_first_syndrome), 32'd1);
    chk_err_state("clr_err");
    drive(10'h013, 1'b0);
    chk_err_state("first_holds");
    drive(10'h213, 1'b0);
    chk_err_state("clean_unchanged");
    idle(2);

    // Backpressure: first word parks, second is held off, then both drain.
    dec_ready = 1'b0;
    word_a = 10'h2A5;
    drive(word_a, 1'b0);
    chk("bp_rcv_ready_low", 32'(rcv_ready), 32'd0);
    fork
      drive(10'h1C3, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          tick();
          chk("bp_hold_valid", 32'(dec_valid), 32'd1);
          chk("bp_hold_word", 32'(dec_codeword), 32'(word_a));
          chk("bp_hold_ready", 32'(rcv_ready), 32'd0);
        end
        dec_ready = 1'b1;
      end
    join
    idle(2);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk_err_state("bp");

    // Reset while a word is stalled drops it.
    dec_ready = 1'b0;
    drive(10'h00E, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
    chk("midrst_count", 32'(err_count), 32'd0);
    chk("midrst_rcv_ready", 32'(rcv_ready), 32'd1);
    exp_q.delete();
    model_reset();
    rst = 1'b0;
    dec_ready = 1'b1;
    tick();
    chk_err_state("midrst");

    // Random words under random backpressure and occasional clears.
    bp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          drive(CW'($urandom_range(0, (1 << CW) - 1)), ($urandom_range(0, 7) == 0));
          chk("rnd_lat", 32'(dec_valid), 32'd1);
          chk_err_state("rnd");
        end
        bp_en = 1'b0;
      end
      begin
        while (bp_en) begin
          tick();
          dec_ready = ($urandom_range(0, 3) != 0);
        end
        dec_ready = 1'b1;
      end
    join
    idle(4);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_dec_valid", 32'(dec_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/br_ecc_sed_chunked_decoder.md
BR_ECC_SED_CHUNKED_DECODER -- requirements
Module: br_ecc_sed_chunked_decoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DataWidth, 8, message bits; must be at least 1.
- ChunkWidth, 4, data bits covered by each parity bit; must be 1 to DataWidth.
- ErrorCountWidth, 8, width of the error counter; must be at least 1.
- EnableAssertFinalNotValid, 1, if 1, assert no valid is high at the end of the test.
REQ-002 Localparams SHALL be NumChunks = ceil(DataWidth/ChunkWidth), ParityWidth = NumChunks, and CodewordWidth = DataWidth + ParityWidth.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, positive-edge clock.
- rst, in, 1, synchronous active-high reset.
- rcv_valid, in, 1, input codeword valid.
- rcv_ready, out, 1, input ready.
- rcv_codeword, in, CodewordWidth, received codeword.
- dec_valid, out, 1, output valid.
- dec_ready, in, 1, output ready.
- dec_codeword, out, CodewordWidth, codeword passed through.
- dec_data, out, DataWidth, equal to dec_codeword[DataWidth-1:0].
- dec_error_syndrome, out, NumChunks, per-chunk syndrome.
- dec_error_due, out, 1, OR of the syndrome bits.
- err_count, out, ErrorCountWidth, saturating count of errored codewords.
- err_count_clear, in, 1, clears the counter and the sticky state.
- err_sticky, out, 1, an error has been seen since the last clear.
- err_first_syndrome, out, NumChunks, syndrome of the first error since the last clear.

Function
REQ-004 Codeword layout SHALL be {parity, data}: parity bit i sits at bit DataWidth+i and covers data[i*ChunkWidth +: ChunkWidth]; the last chunk is truncated at DataWidth.
REQ-005 Syndrome bit i SHALL equal the XOR of parity bit i and every bit of chunk i, so even parity per chunk gives syndrome 0.
REQ-006 A transfer SHALL occur when rcv_valid && rcv_ready; dec_valid SHALL assert on the next cycle, giving a latency of exactly 1.
REQ-007 rcv_ready SHALL equal !dec_valid || dec_ready, so full throughput (one transfer per cycle) is sustained when dec_ready is held high.
REQ-008 While dec_valid && !dec_ready, dec_codeword, dec_error_syndrome and dec_error_due SHALL hold stable.
REQ-009 Data SHALL always be forwarded uncorrected, whatever the error state.
REQ-010 err_count SHALL increment by 1 on each input transfer whose syndrome is nonzero, counted at acceptance rather than at output.
REQ-011 err_count SHALL saturate at 2^ErrorCountWidth-1 and never wrap.
REQ-012 If err_count_clear is high alone, the next-cycle err_count SHALL be 0, err_sticky 0 and err_first_syndrome 0.
REQ-013 If err_count_clear coincides with an errored transfer, the next-cycle err_count SHALL be 1, err_sticky 1 and err_first_syndrome that transfer's syndrome.
REQ-014 err_first_syndrome SHALL capture only when err_sticky is 0 (or per REQ-013), and SHALL hold on later errors.
REQ-015 With a clean input, err_count, err_sticky and err_first_syndrome SHALL be unchanged.

Reset
REQ-016 When rst is high, the next cycle SHALL show dec_valid=0, err_count=0, err_sticky=0 and err_first_syndrome=0.
REQ-017 The datapath registers (codeword, syndrome) MAY be left unreset.
REQ-018 Reset asserted mid-stream SHALL drop any held output word without presenting it.
REQ-019 rcv_ready SHALL be 1 on the cycle after reset deasserts.

Structure
REQ-020 No new package types SHALL be added; NumChunks SHALL be computed locally with a ceiling division.
REQ-021 The output stage SHALL be one br_flow_reg_fwd instance of width CodewordWidth+NumChunks+1.
REQ-022 The syndrome SHALL be a generate loop over chunks.
REQ-023 The counter and sticky state SHALL be local flops.
REQ-024 Static asserts SHALL check the parameter ranges.
REQ-025 Implementation asserts SHALL check dec_valid stability under backpressure, err_count monotonic between clears, and cover dec_error_due and counter saturation.

Verification (DataWidth=8, ChunkWidth=4, ErrorCountWidth=2)
REQ-026 Sending 10'h213 then 10'h00F SHALL produce dec_valid one cycle later each, syndrome 2'b00, dec_data 8'h13 then 8'h0F, and err_count 0.
REQ-027 Sending 10'h00E then 10'h013 SHALL produce syndromes 2'b01 then 2'b10, due 1 on both, err_count 2, and err_first_syndrome 2'b01.
REQ-028 Five back-to-back errored words SHALL leave err_count at 3 (saturated).
REQ-029 Holding dec_ready low while two words are offered SHALL give rcv_ready 0 after the first transfer and keep the output stable; raising dec_ready SHALL deliver both in order.
REQ-030 Asserting err_count_clear in the same cycle as the accepted 10'h00E SHALL give err_count 1 and err_first_syndrome 2'b01.
REQ-031 Asserting rst while dec_valid is high with dec_ready low SHALL give the next cycle dec_valid 0, err_count 0 and rcv_ready 1.
